// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point add/subtract with valid/ready handshake.
// Define FP_ROUND_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       in_a,
  input  logic [EXP_W+MAN_W:0]       in_b,
  input  logic                       in_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out_res,
  output logic [2:0]                 out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MX = MAN_W + 4;   // {hidden, frac, G, R, S}
  localparam int SW = MAN_W + 5;   // MX plus carry
  localparam int EW = EXP_W + 2;   // signed exponent arithmetic width

  localparam logic [W-1:0]          QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0]  EMAX  = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0]  E_ONE = EW'(1);

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // ---------------- S1: unpack, order by magnitude, detect specials
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb, fa_f, fb_f;
  logic             nan_a, nan_b, inf_a, inf_b;

  assign sa    = in_a[W-1];
  assign sb    = in_b[W-1] ^ in_sub;
  assign ea    = in_a[W-2:MAN_W];
  assign eb    = in_b[W-2:MAN_W];
  assign fa    = in_a[MAN_W-1:0];
  assign fb    = in_b[MAN_W-1:0];
  assign fa_f  = (ea == '0) ? '0 : fa;
  assign fb_f  = (eb == '0) ? '0 : fb;
  assign nan_a = (&ea) & (|fa);
  assign nan_b = (&eb) & (|fb);
  assign inf_a = (&ea) & ~(|fa);
  assign inf_b = (&eb) & ~(|fb);

  logic             l_sign, s_sign;
  logic [EXP_W-1:0] l_exp, s_exp;
  logic [MAN_W:0]   l_man, s_man;

  always_comb begin
    if ({ea, fa_f} >= {eb, fb_f}) begin
      l_sign = sa;  l_exp = ea;  l_man = {|ea, fa_f};
      s_sign = sb;  s_exp = eb;  s_man = {|eb, fb_f};
    end else begin
      l_sign = sb;  l_exp = eb;  l_man = {|eb, fb_f};
      s_sign = sa;  s_exp = ea;  s_man = {|ea, fa_f};
    end
  end

  logic             s1_v, s1_sign_l, s1_sign_s;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [MAN_W:0]   s1_man_l, s1_man_s;
  logic             s1_nan, s1_inval, s1_inf, s1_inf_sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s1_sign_l <= 1'b0; s1_sign_s <= 1'b0;
      s1_exp <= '0; s1_diff <= '0; s1_man_l <= '0; s1_man_s <= '0;
      s1_nan <= 1'b0; s1_inval <= 1'b0; s1_inf <= 1'b0; s1_inf_sign <= 1'b0;
    end else if (advance) begin
      s1_v        <= in_valid;
      s1_sign_l   <= l_sign;
      s1_sign_s   <= s_sign;
      s1_exp      <= l_exp;
      s1_diff     <= l_exp - s_exp;
      s1_man_l    <= l_man;
      s1_man_s    <= s_man;
      s1_nan      <= nan_a | nan_b;
      s1_inval    <= inf_a & inf_b & (sa != sb);
      s1_inf      <= inf_a | inf_b;
      s1_inf_sign <= inf_a ? sa : sb;
    end
  end

  // ---------------- S2: align smaller operand with sticky collection
  logic [MX-1:0] ext_s, al_s;
  logic          stk;

  always_comb begin
    ext_s = {s1_man_s, 3'b000};
    al_s  = '0;
    stk   = 1'b0;
    if (32'(s1_diff) >= MAN_W + 3) begin
      al_s = {{(MX-1){1'b0}}, |s1_man_s};
    end else begin
      al_s = ext_s >> s1_diff;
      for (int unsigned i = 0; i < MX; i++)
        if (i < 32'(s1_diff)) stk = stk | ext_s[i];
      al_s[0] = al_s[0] | stk;
    end
  end

  logic             s2_v, s2_sign, s2_effsub, s2_zsign;
  logic [EXP_W-1:0] s2_exp;
  logic [MX-1:0]    s2_l, s2_s;
  logic             s2_nan, s2_inval, s2_inf, s2_inf_sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0; s2_sign <= 1'b0; s2_effsub <= 1'b0; s2_zsign <= 1'b0;
      s2_exp <= '0; s2_l <= '0; s2_s <= '0;
      s2_nan <= 1'b0; s2_inval <= 1'b0; s2_inf <= 1'b0; s2_inf_sign <= 1'b0;
    end else if (advance) begin
      s2_v        <= s1_v;
      s2_sign     <= s1_sign_l;
      s2_effsub   <= s1_sign_l ^ s1_sign_s;
      s2_zsign    <= s1_sign_l & s1_sign_s;
      s2_exp      <= s1_exp;
      s2_l        <= {s1_man_l, 3'b000};
      s2_s        <= al_s;
      s2_nan      <= s1_nan;
      s2_inval    <= s1_inval;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;
    end
  end

  // ---------------- S3: magnitude add/subtract (larger first, so never negative)
  logic             s3_v, s3_sign, s3_zsign;
  logic [EXP_W-1:0] s3_exp;
  logic [SW-1:0]    s3_sum;
  logic             s3_nan, s3_inval, s3_inf, s3_inf_sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v <= 1'b0; s3_sign <= 1'b0; s3_zsign <= 1'b0; s3_exp <= '0; s3_sum <= '0;
      s3_nan <= 1'b0; s3_inval <= 1'b0; s3_inf <= 1'b0; s3_inf_sign <= 1'b0;
    end else if (advance) begin
      s3_v        <= s2_v;
      s3_sign     <= s2_sign;
      s3_zsign    <= s2_zsign;
      s3_exp      <= s2_exp;
      s3_sum      <= s2_effsub ? ({1'b0, s2_l} - {1'b0, s2_s})
                               : ({1'b0, s2_l} + {1'b0, s2_s});
      s3_nan      <= s2_nan;
      s3_inval    <= s2_inval;
      s3_inf      <= s2_inf;
      s3_inf_sign <= s2_inf_sign;
    end
  end

  // ---------------- S4: normalise, round, pack
  int unsigned             lzc;
  logic [MX-1:0]           norm;
  logic signed [EW-1:0]    e_b, e_n, e_r;
  logic [MAN_W-1:0]        frac;
  logic [W-1:0]            res;
  logic [2:0]              flg;
`ifdef FP_ROUND_RNE_EN
  logic                    inc;
  logic [MAN_W+1:0]        mant_r;
`endif

  always_comb begin
    lzc = MX;
    for (int unsigned i = 0; i < MX; i++)
      if (s3_sum[i]) lzc = MX - 1 - i;
    e_b = $signed({2'b00, s3_exp});
    // carry case keeps the dropped LSB alive in the sticky position
    if (s3_sum[SW-1]) begin
      norm = {s3_sum[SW-1:2], s3_sum[1] | s3_sum[0]};
      e_n  = e_b + E_ONE;
    end else begin
      norm = s3_sum[MX-1:0] << lzc;
      e_n  = e_b - $signed(EW'(lzc));
    end
`ifdef FP_ROUND_RNE_EN
    inc    = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[MX-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    if (mant_r[MAN_W+1]) begin
      e_r  = e_n + E_ONE;
      frac = mant_r[MAN_W:1];
    end else begin
      e_r  = e_n;
      frac = mant_r[MAN_W-1:0];
    end
`else
    e_r  = e_n;
    frac = norm[MX-2:3];
`endif
  end

  always_comb begin
    res = '0;
    flg = '0;
    if (s3_nan || s3_inval) begin
      res    = QNAN;
      flg[2] = s3_inval;
    end else if (s3_inf) begin
      res = {s3_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s3_sum == '0) begin
      res = {s3_zsign, {(W-1){1'b0}}};
    end else if (e_n < E_ONE) begin
      res    = {s3_sign, {(W-1){1'b0}}};
      flg[0] = 1'b1;
    end else if (e_r >= EMAX) begin
      res    = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg[1] = 1'b1;
    end else begin
      res = {s3_sign, e_r[EXP_W-1:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_flags <= '0;
    end else if (advance) begin
      out_valid <= s3_v;
      out_res   <= res;
      out_flags <= flg;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: single- and half-precision instances, directed vectors.
module tb_fp_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] in_a = '0, in_b = '0, out_res;
  logic [2:0]  out_flags;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags)
  );

  logic        h_in_valid = 1'b0, h_in_sub = 1'b0, h_out_ready = 1'b1;
  logic        h_in_ready, h_out_valid;
  logic [15:0] h_in_a = '0, h_in_b = '0, h_out_res;
  logic [2:0]  h_out_flags;

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out_res(h_out_res), .out_flags(h_out_flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          t_acc;
    bit          chk_lat;
  } item_t;

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  item_t q[$];
  item_t hq[$];
  item_t mit, hit;
  vec_t  dv[13];
  vec_t  bb[8];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] er, input logic [2:0] ef, input bit push, input bit lat);
    int  n;
    bit  ok;
    item_t it;
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: operand %h/%h not accepted in 50 cycles, expected acceptance", a, b);
    end else if (push) begin
      it.res = er; it.flg = ef; it.t_acc = cyc; it.chk_lat = lat;
      q.push_back(it);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || hq.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 64'(q.size() + hq.size()), 64'd0);
  endtask

  // Monitor: stalled outputs must already show the next expected result
  always @(negedge clk) begin
    if (rst_n && mon_en && out_valid) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got res=%h flags=%b, expected no output", out_res, out_flags);
      end else begin
        mit = q[0];
        if (!out_ready) begin
          check("stall_hold", {out_flags, out_res}, {mit.flg, mit.res});
        end else begin
          void'(q.pop_front());
          check("result", {out_flags, out_res}, {mit.flg, mit.res});
          if (mit.chk_lat) check("latency", 64'(cyc - mit.t_acc + 1), 64'd4);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && h_out_valid) begin
      if (hq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL half_unexpected: got res=%h, expected no output", h_out_res);
      end else begin
        hit = hq.pop_front();
        check("half_result", {h_out_flags, h_out_res}, {hit.flg, hit.res[15:0]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit    stale;
    item_t hi;

    dv[0]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000};
    dv[1]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    dv[2]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100};
    dv[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
`ifdef FP_ROUND_RNE_EN
    dv[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000};
`else
    dv[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 3'b000};
`endif
    dv[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000};
    dv[6]  = '{32'hFFC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
    dv[7]  = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 3'b000};
    dv[8]  = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
    dv[9]  = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b001};
    dv[10] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b000};
    dv[11] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000};
    dv[12] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};

    bb[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000};
    bb[1] = '{32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000};
    bb[2] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
    bb[3] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000};
    bb[4] = '{32'h40A00000, 32'h40400000, 1'b0, 32'h41000000, 3'b000};
    bb[5] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000};
    bb[6] = '{32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 3'b000};
    bb[7] = '{32'h41200000, 32'h41200000, 1'b1, 32'h00000000, 3'b000};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_res",   64'(out_res),   64'd0);
    check("reset_out_flags", 64'(out_flags), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b1, 1'b1);
    drain();

    for (int i = 0; i < 13; i++)
      send(dv[i].a, dv[i].b, dv[i].sub, dv[i].res, dv[i].flg, 1'b1, 1'b0);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++)
          send(bb[i].a, bb[i].b, bb[i].sub, bb[i].res, bb[i].flg, 1'b1, 1'b0);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
          @(negedge clk);
          n++;
        end
        if (!out_valid) begin
          n_chk++; n_fail++;
          $display("FAIL stall_start: out_valid=0 after 60 cycles, expected 1");
        end
        @(posedge clk); #2;
        @(posedge clk); #2;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("in_ready_stall", 64'(in_ready), 64'd0);
          @(posedge clk); #2;
        end
        out_ready = 1'b1;
      end
    join
    @(posedge clk); #1;
    drain();

    // Fill the pipe under backpressure, then reset with a result held at the output
    mon_en = 1'b0;
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, '0, '0, 1'b0, 1'b0);
    send(32'h40000000, 32'h3F800000, 1'b0, '0, '0, 1'b0, 1'b0);
    send(32'h40400000, 32'h3F800000, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_valid", 64'(out_valid), 64'd0);
    check("reset_mid_res",   64'(out_res),   64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    mon_en = 1'b1;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_output", 64'(stale), 64'd0);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    check("half_in_ready", 64'(h_in_ready), 64'd1);
    h_in_a = 16'h3C00; h_in_b = 16'h3C00; h_in_sub = 1'b0; h_in_valid = 1'b1;
    hi.res = 32'h00004000; hi.flg = 3'b000; hi.t_acc = 0; hi.chk_lat = 1'b0;
    hq.push_back(hi);
    @(posedge clk); #1;
    h_in_a = 16'h4000; h_in_b = 16'h3C00; h_in_sub = 1'b1;
    hi.res = 32'h00003C00;
    hq.push_back(hi);
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
